pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipelined-plus-cache core. Drives the `en` (stall, active-low hold) and `rst_n`-style flush (active-low clear) inputs of the PC register and the F/D, D/E, E/M and M/W pipeline registers. Resolves load-use hazards, branch/jump redirects, I-cache misses and D-cache misses with a single prioritised state machine, and keeps two performance counters.

---
 rtl/pipeline_pkg.sv | 32 +++
 rtl/hazard_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_BUBBLE   = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_I_MISS   = 3'd3,
        ST_D_MISS   = 3'd4
    } hz_state_t;

    // Enable vector ordering: {pc, fd, de, em, mw}
    localparam logic [4:0] EN_ALL     = 5'b11111;
    localparam logic [4:0] EN_NONE    = 5'b00000;
    localparam logic [4:0] EN_HOLD_FE = 5'b00111;
    localparam logic [4:0] EN_HOLD_PC = 5'b01111;

    // Flush vector ordering: {fd_n, de_n}
    function automatic logic [1:0] flush_decode(input hz_state_t s);
        logic [1:0] f;
        case (s)
            ST_BUBBLE:   f = 2'b10;
            ST_REDIRECT: f = 2'b00;
            ST_I_MISS:   f = 2'b01;
            default:     f = 2'b11;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
module hazard_detect #(
    parameter int ADDR_W = pipeline_pkg::REG_ADDR_WIDTH
) (
    input  logic              i_mem_read_e,
    input  logic [ADDR_W-1:0] i_rd_e,
    input  logic [ADDR_W-1:0] i_rs1_d,
    input  logic [ADDR_W-1:0] i_rs2_d,
    output logic              o_lu
);

    logic w_rd_nonzero;
    logic w_src_match;

    // x0 is hardwired zero, so a load into it never creates a dependency
    assign w_rd_nonzero = (i_rd_e != '0);
    assign w_src_match  = (i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d);
    assign o_lu         = i_mem_read_e && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - prioritised stall/flush controller with performance counters
module pipeline_hazard_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_e,
    input  logic                      i_mem_read_e,
    input  logic                      i_pc_src_e,
    input  logic                      i_imiss_f,
    input  logic                      i_irefill_done,
    input  logic                      i_dmiss_m,
    input  logic                      i_drefill_done,
    output logic                      o_en_pc,
    output logic                      o_en_fd,
    output logic                      o_en_de,
    output logic                      o_en_em,
    output logic                      o_en_mw,
    output logic                      o_flush_fd_n,
    output logic                      o_flush_de_n,
    output logic [DATA_WIDTH-1:0]     o_stall_cycles,
    output logic [DATA_WIDTH-1:0]     o_flush_events
);

    import pipeline_pkg::*;

    hz_state_t             r_state;
    hz_state_t             w_next;
    logic [4:0]            w_en;
    logic                  w_lu;
    logic [1:0]            r_flush;
    logic [DATA_WIDTH-1:0] r_stall_cycles;
    logic [DATA_WIDTH-1:0] r_flush_events;

    hazard_detect #(
        .ADDR_W (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .i_mem_read_e (i_mem_read_e),
        .i_rd_e       (i_rd_e),
        .i_rs1_d      (i_rs1_d),
        .i_rs2_d      (i_rs2_d),
        .o_lu         (w_lu)
    );

    always_comb begin
        w_next = r_state;
        w_en   = EN_ALL;
        case (r_state)
            ST_D_MISS: begin
                w_en = EN_NONE;
                if (i_drefill_done) begin
                    w_next = ST_RUN;
                end
            end
            ST_I_MISS: begin
                w_en = EN_HOLD_PC;
                if (i_dmiss_m) begin
                    w_next = ST_D_MISS;
                    w_en   = EN_NONE;
                end else if (i_pc_src_e) begin
                    w_next = ST_REDIRECT;
                end else if (i_irefill_done) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next = ST_RUN;
                if (i_dmiss_m) begin
                    w_next = ST_D_MISS;
                    w_en   = EN_NONE;
                end else if (i_pc_src_e && (r_state != ST_REDIRECT)) begin
                    // In REDIRECT, E holds the bubble just flushed in, so pc_src_e is stale
                    w_next = ST_REDIRECT;
                end else if (i_imiss_f) begin
                    w_next = ST_I_MISS;
                    w_en   = EN_HOLD_FE;
                end else if (w_lu) begin
                    w_next = ST_BUBBLE;
                    w_en   = EN_HOLD_FE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_RUN;
            r_flush        <= 2'b11;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_state <= w_next;
            r_flush <= flush_decode(w_next);
            if (!w_en[4]) begin
                r_stall_cycles <= r_stall_cycles + DATA_WIDTH'(1);
            end
            if ((w_next == ST_REDIRECT) && (r_state != ST_REDIRECT)) begin
                r_flush_events <= r_flush_events + DATA_WIDTH'(1);
            end
        end
    end

    // Reset holds every register closed and cleared regardless of state
    assign o_en_pc        = w_en[4] & i_rst_n;
    assign o_en_fd        = w_en[3] & i_rst_n;
    assign o_en_de        = w_en[2] & i_rst_n;
    assign o_en_em        = w_en[1] & i_rst_n;
    assign o_en_mw        = w_en[0] & i_rst_n;
    assign o_flush_fd_n   = r_flush[1] & i_rst_n;
    assign o_flush_de_n   = r_flush[0] & i_rst_n;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    typedef struct {
        string      nm;
        logic [4:0] en;
        logic [1:0] fl;
        int         st;
        int         fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_d = '0;
    logic [4:0]  rs2_d = '0;
    logic [4:0]  rd_e = '0;
    logic        mem_read_e = 1'b0;
    logic        pc_src_e = 1'b0;
    logic        imiss_f = 1'b0;
    logic        irefill_done = 1'b0;
    logic        dmiss_m = 1'b0;
    logic        drefill_done = 1'b0;
    logic        en_pc, en_fd, en_de, en_em, en_mw;
    logic        flush_fd_n, flush_de_n;
    logic [31:0] stall_cycles, flush_events;

    logic        s_mr = 1'b0;
    logic [4:0]  s_rd = '0;
    logic [4:0]  s_rs1 = '0;
    logic [4:0]  s_rs2 = '0;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    pipeline_hazard_ctrl #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rs1_d        (rs1_d),
        .i_rs2_d        (rs2_d),
        .i_rd_e         (rd_e),
        .i_mem_read_e   (mem_read_e),
        .i_pc_src_e     (pc_src_e),
        .i_imiss_f      (imiss_f),
        .i_irefill_done (irefill_done),
        .i_dmiss_m      (dmiss_m),
        .i_drefill_done (drefill_done),
        .o_en_pc        (en_pc),
        .o_en_fd        (en_fd),
        .o_en_de        (en_de),
        .o_en_em        (en_em),
        .o_en_mw        (en_mw),
        .o_flush_fd_n   (flush_fd_n),
        .o_flush_de_n   (flush_de_n),
        .o_stall_cycles (stall_cycles),
        .o_flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic set_lu(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        s_mr  = mr;
        s_rd  = rd;
        s_rs1 = r1;
        s_rs2 = r2;
    endtask

    task automatic step(input string nm, input logic rst, input logic dm, input logic drf,
                        input logic pcs, input logic im, input logic irf,
                        input logic [4:0] en, input logic [1:0] fl, input int st, input int fe);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        dmiss_m      = dm;
        drefill_done = drf;
        pc_src_e     = pcs;
        imiss_f      = im;
        irefill_done = irf;
        mem_read_e   = s_mr;
        rd_e         = s_rd;
        rs1_d        = s_rs1;
        rs2_d        = s_rs2;
        e.nm = nm;
        e.en = en;
        e.fl = fl;
        e.st = st;
        e.fe = fe;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks = n_checks + 4;
            if ({en_pc, en_fd, en_de, en_em, en_mw} !== e.en) begin
                n_fails++;
                $display("FAIL %s en got=%b exp=%b", e.nm, {en_pc, en_fd, en_de, en_em, en_mw}, e.en);
            end
            if ({flush_fd_n, flush_de_n} !== e.fl) begin
                n_fails++;
                $display("FAIL %s flush got=%b exp=%b", e.nm, {flush_fd_n, flush_de_n}, e.fl);
            end
            if (stall_cycles !== 32'(e.st)) begin
                n_fails++;
                $display("FAIL %s stall_cycles got=%0d exp=%0d", e.nm, stall_cycles, e.st);
            end
            if (flush_events !== 32'(e.fe)) begin
                n_fails++;
                $display("FAIL %s flush_events got=%0d exp=%0d", e.nm, flush_events, e.fe);
            end
        end
    end

    initial begin
        // step(name, rst_n, dmiss, drefill, pc_src, imiss, irefill, en{pc,fd,de,em,mw}, flush{fd,de}, stall, flushes)
        step("reset",       0, 0,0,0,0,0, 5'b00000, 2'b00, 0, 0);
        step("release",     1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 0);
        set_lu(1, 5'd5, 5'd5, 5'd0);
        step("lu_stall",    1, 0,0,0,0,0, 5'b00111, 2'b11, 0, 0);
        set_lu(0, 5'd0, 5'd0, 5'd0);
        step("lu_bubble",   1, 0,0,0,0,0, 5'b11111, 2'b10, 1, 0);
        step("lu_resume",   1, 0,0,0,0,0, 5'b11111, 2'b11, 1, 0);
        set_lu(1, 5'd0, 5'd0, 5'd0);
        step("lu_rd_zero",  1, 0,0,0,0,0, 5'b11111, 2'b11, 1, 0);
        set_lu(1, 5'd7, 5'd3, 5'd7);
        step("lu_rs2",      1, 0,0,0,0,0, 5'b00111, 2'b11, 1, 0);
        set_lu(0, 5'd0, 5'd0, 5'd0);
        step("lu_rs2_bub",  1, 0,0,0,0,0, 5'b11111, 2'b10, 2, 0);
        set_lu(0, 5'd5, 5'd5, 5'd5);
        step("lu_no_load",  1, 0,0,0,0,0, 5'b11111, 2'b11, 2, 0);
        set_lu(0, 5'd0, 5'd0, 5'd0);

        step("rst2",        0, 0,0,0,0,0, 5'b00000, 2'b00, 0, 0);
        step("rel2",        1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 0);
        step("br_pulse",    1, 0,0,1,0,0, 5'b11111, 2'b11, 0, 0);
        step("br_flush",    1, 0,0,0,0,0, 5'b11111, 2'b00, 0, 1);
        step("br_resume",   1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 1);
        step("br_held1",    1, 0,0,1,0,0, 5'b11111, 2'b11, 0, 1);
        step("br_held2",    1, 0,0,1,0,0, 5'b11111, 2'b00, 0, 2);
        step("br_held_end", 1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 2);
        set_lu(1, 5'd9, 5'd9, 5'd9);
        step("br_prio",     1, 0,0,1,1,0, 5'b11111, 2'b11, 0, 2);
        set_lu(0, 5'd0, 5'd0, 5'd0);
        step("br_prio_fl",  1, 0,0,0,0,0, 5'b11111, 2'b00, 0, 3);
        step("br_prio_run", 1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 3);

        step("rst3",        0, 0,0,0,0,0, 5'b00000, 2'b00, 0, 0);
        step("rel3",        1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 0);
        step("dm_start",    1, 1,0,0,0,0, 5'b00000, 2'b11, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            step("dm_hold",  1, 1,0,0,0,0, 5'b00000, 2'b11, k, 0);
        end
        step("dm_done",     1, 1,1,0,0,0, 5'b00000, 2'b11, 10, 0);
        step("dm_resume",   1, 0,0,0,0,0, 5'b11111, 2'b11, 11, 0);

        step("rst4",        0, 0,0,0,0,0, 5'b00000, 2'b00, 0, 0);
        step("rel4",        1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 0);
        step("im_start",    1, 0,0,0,1,0, 5'b00111, 2'b11, 0, 0);
        step("im_wait1",    1, 0,0,0,1,0, 5'b01111, 2'b01, 1, 0);
        step("im_wait2",    1, 0,0,0,1,0, 5'b01111, 2'b01, 2, 0);
        step("im_br",       1, 0,0,1,1,0, 5'b01111, 2'b01, 3, 0);
        step("im_br_flush", 1, 0,0,0,0,0, 5'b11111, 2'b00, 4, 1);
        step("im_br_run",   1, 0,0,0,0,0, 5'b11111, 2'b11, 4, 1);
        step("im2_start",   1, 0,0,0,1,0, 5'b00111, 2'b11, 4, 1);
        step("im2_refill",  1, 0,0,0,0,1, 5'b01111, 2'b01, 5, 1);
        step("im2_run",     1, 0,0,0,0,0, 5'b11111, 2'b11, 6, 1);
        step("im3_start",   1, 0,0,0,1,0, 5'b00111, 2'b11, 6, 1);

        step("rst_in_imiss",0, 0,0,0,1,0, 5'b00000, 2'b00, 0, 0);
        step("rel5",        1, 0,0,0,0,0, 5'b11111, 2'b11, 0, 0);
        step("sim_start",   1, 1,0,1,0,0, 5'b00000, 2'b11, 0, 0);
        step("sim_hold",    1, 1,0,1,0,0, 5'b00000, 2'b11, 1, 0);
        step("sim_done",    1, 1,1,1,0,0, 5'b00000, 2'b11, 2, 0);
        step("sim_exit",    1, 0,0,1,0,0, 5'b11111, 2'b11, 3, 0);
        step("sim_redir",   1, 0,0,0,0,0, 5'b11111, 2'b00, 3, 1);
        step("sim_run",     1, 0,0,0,0,0, 5'b11111, 2'b11, 3, 1);

        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
